bus_sram_slave: RTL and testbench
=================================

Name: bus_sram_slave

Overview:
- Memory-mapped scratchpad SRAM that responds on the SoC's single-master AHB-Lite-style bus, sitting at a decoder slot alongside the NPU core and the external memory port.
- Protocol is pipelined: the address phase is captured when selected, and a data phase with programmable wait states follows.
- Issues the two-cycle error response for misaligned or out-of-range accesses.
- Provides the bench with a self-checking, latency-configurable slave for bus and CPU load/store verification.

Parameters:
- DWidth, 32, bus data/address width.
- Depth, 256, number of DWidth-bit words stored; power of two, at most 2^(AddrBits-2).
- AddrBits, 16, size of the decoded slave window in bytes = 2^AddrBits; only addr_i[AddrBits-1:0] is examined.
- WaitStates, 1, extra data-phase cycles per OKAY transfer (0..7); 0 = zero-wait.

Ports:
- clk_i  in  1  clock; single clock domain, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- sel_i  in  1  slave select from bus decoder (address-phase qualifier).
- trans_i  in  1  master transfer request (address phase).
- ready_i  in  1  bus-level ready (muxed ready of the slave currently in data phase); address phase is accepted only when high.
- write_i  in  1  1 = write, 0 = read (address phase).
- addr_i  in  DWidth  byte address (address phase).
- wdata_i  in  DWidth  write data, valid during the write's data phase.
- ready_o  out  1  data-phase complete / slave ready.
- resp_o  out  1  0 = OKAY, 1 = ERROR.
- rdata_o  out  DWidth  read data, valid when ready_o=1, resp_o=0, and the current data phase is a read.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, ready_o=1, resp_o=0, rdata_o=0, wait counter=0.
  - Any pending data phase is dropped; a write in progress is not committed.
  - Memory contents are not cleared.
- Address-phase accept:
  - accept = sel_i & trans_i & ready_i at a rising edge.
  - Latches write_i, word index idx = addr_i[AddrBits-1:2], and err = (addr_i[1:0]!=0) | (idx >= Depth).
- State machine (package enum): IDLE, DATA, ERR1, ERR2.
- IDLE:
  - ready_o=1, resp_o=0.
  - On accept with !err: go to DATA, count=WaitStates.
  - On accept with err: go to ERR1.
- DATA:
  - count>0: ready_o=0, resp_o=0, count decrements each cycle.
  - count==0: ready_o=1, resp_o=0 (the completion cycle).
  - Read: rdata_o = mem[idx_q] in the completion cycle.
  - Write: mem[idx_q] <= wdata_i on the completion edge.
  - Back-to-back: a new accept on the completion edge loads the next transfer (DATA or ERR1) with no IDLE bubble. Otherwise return to IDLE.
  - A read whose address phase overlaps a write's completion cycle to the same idx returns the new data, because the write commits before the read data phase.
- ERR1: ready_o=0, resp_o=1, then ERR2. No memory access.
- ERR2:
  - ready_o=1, resp_o=1.
  - Accept is legal here; go to DATA, ERR1 or IDLE exactly as from DATA completion.
- Latency per OKAY transfer: WaitStates+1 data-phase cycles. Error transfers always take 2 cycles, independent of WaitStates.
- Bus rule: ready_o=1 and resp_o=0 whenever no data phase is pending (IDLE).
- rdata_o is 0 outside read completion cycles; it holds no stale data.
- Writes commit only on OKAY completion. Error writes never modify memory.
- sel_i=0 with trans_i=1: ignored, state unaffected. The slave may be in its own data phase while another slave is addressed.
- ready_i=0 during a foreign slave's wait: no accept, even if sel_i=1.

Decomposition:
- Package bus_pkg:
  - state enum {IDLE, DATA, ERR1, ERR2}.
  - RESP_OKAY=1'b0, RESP_ERROR=1'b1.
  - Wait-counter width constant WaitW=3.
- Sub-module bus_sram_array:
  - Depth x DWidth storage.
  - One synchronous write port (we, waddr, wdata); one combinational read port (raddr → rdata).
  - No reset.
- Top holds the FSM, the address-phase registers and the response logic.

Test Plan:
- WaitStates=1: write 0xDEADBEEF to 0x0000_0010, then read 0x10.
  - Each data phase shows ready_o=0 for 1 cycle, then 1.
  - Read returns 0xDEADBEEF with resp_o=0.
- WaitStates=0, back-to-back pipelined sequence: write 0x4 ← 0x11111111, read 0x4, write 0x8 ← 0x22222222, read 0x8.
  - ready_o stays 1 throughout.
  - Reads return 0x11111111 and 0x22222222; no IDLE cycles between transfers.
- Misaligned write to 0x0000_0006 with wdata 0xFFFFFFFF:
  - Response is (ready_o,resp_o) = (0,1) then (1,1).
  - A subsequent read of 0x4 returns its prior value unchanged.
- Out-of-range read at idx=Depth (addr 0x400 for Depth=256):
  - Response is ERR1 then ERR2.
  - A read of 0x0 accepted in the ERR2 cycle completes OKAY with the correct data.
- sel_i=0, trans_i=1 at 0x20, and ready_i held low 3 cycles with sel_i=1:
  - No state change, ready_o=1, resp_o=0.
  - Memory is unmodified.
- rst_i asserted on the wait cycle of a write 0xC ← 0xA5A5A5A5 (WaitStates=2):
  - Next cycle shows ready_o=1, resp_o=0, rdata_o=0.
  - A read of 0xC returns the pre-write value.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the scratchpad SRAM bus slave.
// State encoding, response codes and the wait-counter width.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ERR1,
        ERR2
    } state_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    localparam int WaitW = 3;

endpackage

// File: rtl/bus_sram_array.sv
// Depth x DWidth word storage: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read data follows raddr in the same cycle; no reset, no backpressure.
module bus_sram_array #(
    parameter int DWidth = 32,
    parameter int Depth  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] waddr,
    input  logic [DWidth-1:0]        wdata,
    input  logic [$clog2(Depth)-1:0] raddr,
    output logic [DWidth-1:0]        rdata
);

    logic [DWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_sram_slave.sv
// Pipelined bus slave fronting a scratchpad SRAM, with two-cycle ERROR for misaligned/out-of-range accesses.
// OKAY transfers take WaitStates+1 data-phase cycles (ready_o low while waiting); address phase taken only when ready_i is high.
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter int DWidth     = 32,
    parameter int Depth      = 256,
    parameter int AddrBits   = 16,
    parameter int WaitStates = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sel_i,
    input  logic              trans_i,
    input  logic              ready_i,
    input  logic              write_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    output logic              ready_o,
    output logic              resp_o,
    output logic [DWidth-1:0] rdata_o
);

    localparam int IdxW  = $clog2(Depth);
    localparam int WordW = AddrBits - 2;
    localparam logic [WordW:0]     DepthW   = (WordW + 1)'(Depth);
    localparam logic [WaitW-1:0]   WaitInit = WaitW'(WaitStates);

    state_t            state;
    logic [WaitW-1:0]  cnt;
    logic              write_q;
    logic [IdxW-1:0]   idx_q;

    logic              accept;
    logic              addr_err;
    logic              done;
    logic              mem_we;
    logic [WordW-1:0]  word;
    logic [DWidth-1:0] mem_rdata;
    logic              unused_bits;

    assign accept   = sel_i & trans_i & ready_i;
    assign word     = addr_i[AddrBits-1:2];
    assign addr_err = (addr_i[1:0] != 2'b00) || ({1'b0, word} >= DepthW);

    // A completing data phase (OKAY or ERR2) frees the slave for a new address phase on the same edge.
    assign done     = ((state == DATA) && (cnt == '0)) || (state == ERR2);
    assign mem_we   = (state == DATA) && (cnt == '0) && write_q && !rst_i;

    assign unused_bits = ^{addr_i[DWidth-1:AddrBits], word[WordW-1:IdxW]};

    bus_sram_array #(
        .DWidth(DWidth),
        .Depth (Depth)
    ) u_array (
        .clk  (clk_i),
        .we   (mem_we),
        .waddr(idx_q),
        .wdata(wdata_i),
        .raddr(idx_q),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            ready_o <= 1'b1;
            resp_o  <= RESP_OKAY;
        end else if (state == IDLE || done) begin
            if (accept) begin
                write_q <= write_i;
                idx_q   <= word[IdxW-1:0];
                if (addr_err) begin
                    state   <= ERR1;
                    ready_o <= 1'b0;
                    resp_o  <= RESP_ERROR;
                end else begin
                    state   <= DATA;
                    cnt     <= WaitInit;
                    ready_o <= (WaitStates == 0);
                    resp_o  <= RESP_OKAY;
                end
            end else begin
                state   <= IDLE;
                ready_o <= 1'b1;
                resp_o  <= RESP_OKAY;
            end
        end else if (state == ERR1) begin
            state   <= ERR2;
            ready_o <= 1'b1;
            resp_o  <= RESP_ERROR;
        end else begin
            cnt     <= cnt - 1'b1;
            ready_o <= (cnt == 3'd1);
            resp_o  <= RESP_OKAY;
        end
    end

    assign rdata_o = ((state == DATA) && (cnt == '0) && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Three slaves (WaitStates 0,1,2) on one bus; bench acts as master and ready mux, checking against a word-level model.
module tb_bus_sram_slave;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AB    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, trans, write, ready_bus;
    logic [2:0]  sel;
    logic [31:0] addr, wdata;
    logic        rdy [3];
    logic        rsp [3];
    logic [31:0] rd  [3];

    bus_sram_slave #(.DWidth(DW), .Depth(DEPTH), .AddrBits(AB), .WaitStates(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel[0]), .trans_i(trans), .ready_i(ready_bus),
        .write_i(write), .addr_i(addr), .wdata_i(wdata),
        .ready_o(rdy[0]), .resp_o(rsp[0]), .rdata_o(rd[0]));

    bus_sram_slave #(.DWidth(DW), .Depth(DEPTH), .AddrBits(AB), .WaitStates(1)) u_ws1 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel[1]), .trans_i(trans), .ready_i(ready_bus),
        .write_i(write), .addr_i(addr), .wdata_i(wdata),
        .ready_o(rdy[1]), .resp_o(rsp[1]), .rdata_o(rd[1]));

    bus_sram_slave #(.DWidth(DW), .Depth(DEPTH), .AddrBits(AB), .WaitStates(2)) u_ws2 (
        .clk_i(clk), .rst_i(rst), .sel_i(sel[2]), .trans_i(trans), .ready_i(ready_bus),
        .write_i(write), .addr_i(addr), .wdata_i(wdata),
        .ready_o(rdy[2]), .resp_o(rsp[2]), .rdata_o(rd[2]));

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          gap;
    } txn_t;

    txn_t        pend[$];
    logic [31:0] mem_m [3][DEPTH];
    int          total = 0;
    int          bad   = 0;

    function automatic bit is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (int'(a[AB-1:2]) >= DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AB-1:2]);
    endfunction

    // Master + ready mux: issues queued transfers, checks every slave each cycle against the model.
    task automatic run_pending(input string name);
        txn_t        dp;
        bit          have_dp = 0;
        int          dp_c = 0;
        int          len;
        bit          exp_rdy;
        bit          issuing;
        int          gap_left;
        int          guard = 0;
        logic        e_rdy, e_rsp;
        logic [31:0] e_rd;
        gap_left = (pend.size() > 0) ? pend[0].gap : 0;
        while ((pend.size() > 0 || have_dp) && guard < 5000) begin
            guard++;
            len     = have_dp ? (is_err(dp.a) ? 2 : dp.k + 1) : 0;
            exp_rdy = !have_dp || (dp_c == len - 1);
            issuing = (pend.size() > 0) && (gap_left == 0);
            sel = 3'b000;
            if (issuing) begin
                sel[pend[0].k] = 1'b1;
                trans = 1'b1;
                write = pend[0].wr;
                addr  = pend[0].a;
            end else begin
                trans = 1'($urandom_range(0, 1));
                write = 1'($urandom_range(0, 1));
                addr  = $urandom;
            end
            wdata     = (have_dp && dp.wr) ? dp.d : $urandom;
            ready_bus = exp_rdy;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (have_dp && dp.k == k) begin
                    e_rdy = exp_rdy;
                    e_rsp = is_err(dp.a);
                    e_rd  = (exp_rdy && !dp.wr && !e_rsp) ? mem_m[k][widx(dp.a)] : 32'h0;
                end else begin
                    e_rdy = 1'b1;
                    e_rsp = 1'b0;
                    e_rd  = 32'h0;
                end
                total++;
                if (rdy[k] !== e_rdy) begin
                    bad++;
                    $display("FAIL %s ready s%0d step%0d: got %b want %b", name, k, guard, rdy[k], e_rdy);
                end
                total++;
                if (rsp[k] !== e_rsp) begin
                    bad++;
                    $display("FAIL %s resp s%0d step%0d: got %b want %b", name, k, guard, rsp[k], e_rsp);
                end
                total++;
                if (rd[k] !== e_rd) begin
                    bad++;
                    $display("FAIL %s rdata s%0d step%0d: got %h want %h", name, k, guard, rd[k], e_rd);
                end
            end
            @(posedge clk);
            if (have_dp && exp_rdy) begin
                if (dp.wr && !is_err(dp.a)) mem_m[dp.k][widx(dp.a)] = dp.d;
                have_dp = 0;
            end else if (have_dp) begin
                dp_c++;
            end
            if (issuing && exp_rdy) begin
                dp       = pend.pop_front();
                have_dp  = 1;
                dp_c     = 0;
                gap_left = (pend.size() > 0) ? pend[0].gap : 0;
            end else if (!issuing && gap_left > 0) begin
                gap_left--;
            end
            #1;
        end
        total++;
        if (guard >= 5000) begin
            bad++;
            $display("FAIL %s budget: got %0d steps want <5000", name, guard);
        end
        trans     = 1'b0;
        sel       = 3'b000;
        ready_bus = 1'b1;
    endtask

    task automatic check_idle(input string name, input int k);
        total++;
        if (rdy[k] !== 1'b1 || rsp[k] !== 1'b0 || rd[k] !== 32'h0) begin
            bad++;
            $display("FAIL %s s%0d: got rdy=%b resp=%b rdata=%h want 1 0 0", name, k, rdy[k], rsp[k], rd[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; trans = 1'b0; sel = 3'b000; write = 1'b0;
        addr = 32'h0; wdata = 32'h0; ready_bus = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle("reset", k);
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++)
                pend.push_back('{k, 1'b1, 32'(i * 4), $urandom, 0});
        run_pending("fill");
    endtask

    task automatic test_wait_states();
        pend.push_back('{1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 0});
        pend.push_back('{1, 1'b0, 32'h0000_0010, 32'h0, 1});
        run_pending("ws1_wr_rd");
    endtask

    task automatic test_back_to_back();
        pend.push_back('{0, 1'b1, 32'h4, 32'h11111111, 0});
        pend.push_back('{0, 1'b0, 32'h4, 32'h0, 0});
        pend.push_back('{0, 1'b1, 32'h8, 32'h22222222, 0});
        pend.push_back('{0, 1'b0, 32'h8, 32'h0, 0});
        run_pending("b2b_ws0");
    endtask

    task automatic test_misaligned();
        pend.push_back('{1, 1'b1, 32'h6, 32'hFFFFFFFF, 0});
        pend.push_back('{1, 1'b0, 32'h4, 32'h0, 0});
        run_pending("misaligned");
    endtask

    task automatic test_out_of_range();
        pend.push_back('{1, 1'b0, 32'h400, 32'h0, 0});
        pend.push_back('{1, 1'b0, 32'h0, 32'h0, 0});
        run_pending("out_of_range");
    endtask

    task automatic test_ignored();
        trans = 1'b1; write = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF;
        sel = 3'b000; ready_bus = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("unselected", 0);
            @(posedge clk);
            #1;
        end
        sel = 3'b001; ready_bus = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("ready_low", 0);
            @(posedge clk);
            #1;
        end
        trans = 1'b0; sel = 3'b000; ready_bus = 1'b1;
        pend.push_back('{0, 1'b0, 32'h20, 32'h0, 0});
        run_pending("ignored_readback");
    endtask

    task automatic test_reset_write();
        sel = 3'b100; trans = 1'b1; write = 1'b1; addr = 32'hC; ready_bus = 1'b1;
        @(posedge clk);
        #1;
        sel = 3'b000; trans = 1'b0; wdata = 32'hA5A5A5A5; ready_bus = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++;
        if (rdy[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait ready: got %b want 0", rdy[2]);
        end
        @(posedge clk);
        #1 rst = 1'b0; ready_bus = 1'b1;
        @(negedge clk);
        check_idle("rst_after", 2);
        @(posedge clk);
        #1;
        pend.push_back('{2, 1'b0, 32'hC, 32'h0, 0});
        run_pending("rst_readback");
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r == 0)      a[AB-1:0] = {14'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            else if (r == 1) a[AB-1:0] = {14'($urandom_range(DEPTH, 16383)), 2'b00};
            else             a[AB-1:0] = {14'($urandom_range(0, DEPTH - 1)), 2'b00};
            pend.push_back('{$urandom_range(0, 2), 1'($urandom_range(0, 1)), a, $urandom,
                             ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : 0});
        end
        run_pending("random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_wait_states();
        test_back_to_back();
        test_misaligned();
        test_out_of_range();
        test_ignored();
        test_reset_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
